// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5-9 data bits, 1-2 stop bits, per-frame error flags, FWFT RX FIFO.
// Optional parity is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 ||
        STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter combination");
    end

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AddrW = PtrW - 1;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned EntryW = DATA_BITS + 2;
`else
    localparam int unsigned EntryW = DATA_BITS + 1;
`endif
    localparam logic [CntW-1:0] HalfCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitCnt   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StCommit
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  prev_q;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                  perr_q, perr_d;
`endif
    logic                  rxd_s, fall, tick;

    logic [EntryW-1:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_q, rd_q;
    logic [EntryW-1:0]     entry, head;
    logic                  empty, full, pop, push_req, push, overrun_q;

    assign rxd_s = sync_q[1];
    assign fall  = prev_q & ~rxd_s;
    assign tick  = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rxd};
            prev_q    <= rxd_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? BitCnt : cnt_q - CntW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = cnt_q;
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = HalfCnt;
                    idx_d   = '0;
                    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            StStart: begin
                if (tick) state_d = rxd_s ? StIdle : StData;
            end
            StData: begin
                if (tick) begin
                    // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LastData) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = (PARITY != 0) ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    perr_d  = rxd_s ^ (^shift_q) ^ (PARITY == 2);
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    ferr_d = ferr_q | ~rxd_s;
                    if (idx_q == LastStop) state_d = StCommit;
                    else                   idx_d   = idx_q + 4'd1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
    assign entry = {perr_q, ferr_q, shift_q};
`else
    assign entry = {ferr_q, shift_q};
`endif

    assign empty    = (wr_q == rd_q);
    assign full     = ((wr_q ^ rd_q) == {1'b1, {AddrW{1'b0}}});
    assign pop      = ~empty & rx_ready;
    assign push_req = (state_q == StCommit);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    assign push     = push_req & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            overrun_q <= push_req & full & ~pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AddrW-1:0]] <= entry;
    end

    assign head      = mem_q[rd_q[AddrW-1:0]];
    assign rx_valid  = ~empty;
    assign rx_data   = empty ? '0 : head[DATA_BITS-1:0];
    assign frame_err = ~empty & head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign parity_err = ~empty & head[DATA_BITS+1];
`else
    assign parity_err = 1'b0;
`endif
    assign overrun = overrun_q;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver; successor to the fixed 8N1 receiver in the oscilloscope firmware. Runtime-fixed frame format (5–9 data bits, optional parity, 1 or 2 stop bits), per-frame framing/parity error reporting and a small first-word-fall-through RX FIFO with valid/ready handshake. It sits between the `rxd` pin and the host command decoder, so the decoder can stall without losing bytes.

## Interface
- `CLKS_PER_BIT`, 434, clocks per bit period; must be at least 4.
- `DATA_BITS`, 8, data bits per frame, 5..9, LSB first.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd. Effective only with `UART_RX_PARITY_EN`.
- `STOP_BITS`, 1, 1 or 2.
- `FIFO_DEPTH`, 4, RX FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rxd`  in  1  serial input, asynchronous, idles high.
- `rx_data`  out  DATA_BITS  head-of-FIFO data; zero when empty.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head entry.
- `frame_err`  out  1  head entry had a stop bit sampled low.
- `parity_err`  out  1  head entry had a parity mismatch.
- `overrun`  out  1  one-cycle pulse when a complete frame is dropped because the FIFO is full.
- `busy`  out  1  receiver is inside a frame.

Reset values: `rx_data` 0, `rx_valid` 0, `frame_err` 0, `parity_err` 0, `overrun` 0, `busy` 0.

## Operation
- **Synchroniser.** `rxd` passes through a 2-FF synchroniser, reset to 1. A falling edge is detected on the synchronised signal (previous value 1, current value 0).
- **FSM states.** IDLE, START, DATA, PARITY, STOP, COMMIT.
- **IDLE.** Falling edge moves to START, sets `busy`, and loads the bit counter.
- **START.** Samples at CLKS_PER_BIT/2 clocks (integer division) after edge detection.
  - Sample 0: go to DATA.
  - Sample 1: false start; go to IDLE and clear `busy`. No FIFO write.
- **DATA.** Samples every CLKS_PER_BIT clocks and shifts into bit `index` (LSB first). After DATA_BITS samples, go to PARITY if parity is enabled, else STOP.
- **PARITY.** Samples one bit. `parity_err` = sampled bit XOR expected parity.
  - Even: expected = XOR of the data bits.
  - Odd: expected = inverse of that XOR.
- **STOP.** Takes STOP_BITS samples, CLKS_PER_BIT apart. Any sample of 0 sets `frame_err` for this frame. After the last sample, go to COMMIT.
- **COMMIT (one cycle).** Pushes {parity_err, frame_err, data} into the FIFO, then goes to IDLE and clears `busy`.
  - Frames with errors are still stored.
  - If the FIFO is full and no pop occurs in the same cycle, the frame is dropped and `overrun` pulses.
  - Full FIFO with a simultaneous pop: the push is accepted and there is no overrun.
- **Break (line held low).** The frame is stored with `frame_err`=1. No new frame starts until a fresh 1→0 edge occurs.
- **FIFO.** Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
  - Pop happens on `rx_valid && rx_ready`. A pop while empty is ignored.
  - Outputs show the head entry combinationally from FIFO storage.
  - Push and pop in the same cycle while empty: the push happens and the pop is ignored.
- **Reset mid-frame.** The frame is discarded, the FIFO is emptied and the FSM returns to IDLE.

## Timing
- Edge detection occurs 2–3 clocks after `rxd` falls, because of the synchroniser.
- Start sample: CLKS_PER_BIT/2 clocks after detection. Data bit k is sampled (k+1)·CLKS_PER_BIT clocks after the start sample.
- Latency from last stop sample to `rx_valid`:
  - Last stop sample at edge S, COMMIT at edge S+1.
  - `rx_valid` is high after S+1 if the FIFO was empty.
  - `overrun`, if any, is high for the cycle following S+1.
- Pop: the entry is removed at the edge where `rx_valid && rx_ready`. The next entry, or `rx_valid`=0, is visible after that edge.
- Back-to-back frames: the receiver is in IDLE by mid-stop-bit + 2 clocks, so a start bit immediately following the stop bit is detected.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present; PARITY values 1 and 2 are honoured.
  - PARITY=0 behaves as no parity.
- Not defined:
  - PARITY state and logic are removed and the PARITY parameter is ignored.
  - The frame is start + DATA_BITS + STOP_BITS.
  - `parity_err` is tied to 0 and the FIFO entry is one bit narrower.

## Test plan
Unless stated otherwise, benches use CLKS_PER_BIT=8, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.

1. **8N1 basic.** Send 0x3F → one entry: `rx_data`=0x3F, both error flags 0. Pop with `rx_ready`=1 → `rx_valid` falls.
2. **Even parity** (`UART_RX_PARITY_EN`, PARITY=1).
   - Send 0xAB with parity bit 1 → `parity_err`=0.
   - Send 0xAB with parity bit 0 → entry 0xAB with `parity_err`=1.
3. **Framing.** Send 0x55 with stop bit 0 → entry 0x55 with `frame_err`=1, `parity_err`=0.
4. **Glitch.** Hold `rxd` low for 2 clocks → `busy` returns to 0 within 8 clocks; `rx_valid` stays 0.
5. **Overrun.** With `rx_ready`=0, send 0x01..0x05.
   - Exactly one `overrun` pulse, after the 5th frame.
   - Then draining with `rx_ready`=1 yields 0x01, 0x02, 0x03, 0x04, after which `rx_valid`=0.
6. **Reset mid-frame.** Pulse `rst_n` low during data bit 3 → all outputs at reset values. The next frame 0x9C is received correctly with no error flags.
